bus_timer_irq: RTL

//   Memory-mapped programmable down-counter: the peripheral side of the CPU's

---
 rtl/bus_timer_irq_if.sv | 37 +++
 rtl/bus_timer_irq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bus_timer_irq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer_irq_if
//  Description : Register-bus bundle between the CPU load/store bridge
//                (master) and the bus_timer_irq peripheral (slave). It also
//                carries the timer's interrupt request back to the CPU side.
//                  we    : write strobe, sampled on the clock edge
//                  addr  : word select (byte address bits [3:2])
//                  wdata : write data
//                  rdata : combinational read data for addr
//                  irq   : interrupt request to a HWInt line
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_timer_irq_if;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output irq
    );
endinterface
`default_nettype wire

// File: rtl/bus_timer_irq.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timer_irq
//  Description : Memory-mapped programmable down-counter that raises an
//                interrupt request on expiry. Software programs it through
//                bridge loads/stores.
//                Register map (word address):
//                  0 CTRL   [0] EN, [2:1] MODE (00/1x one-shot, 01 reload),
//                           [3] IM (irq mask enable). Upper bits read 0.
//                           Any write also acknowledges (clears) the flag.
//                  1 PRESET reload value
//                  2 COUNT  current count, read-only
//                  3 reserved, reads 0
//                Ports:
//                  clk   : clock, rising edge
//                  reset : synchronous, active-high
//                  bus   : slave side of bus_timer_irq_if (we, addr, wdata,
//                          rdata, irq)
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timer_irq #(
    parameter logic [31:0] PRESET_RST = 32'd0,
    parameter int          CNT_W      = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    bus_timer_irq_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Register map constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IM = 3;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [3:0]         ctrl_q,  ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flag_q,  flag_d;

    // ------------------------------------------------------------------------
    // Bus write decode
    // ------------------------------------------------------------------------
    logic w_ctrl_wr;
    logic w_preset_wr;
    logic w_en;
    logic w_reload_mode;
    logic w_count_zero;

    assign w_ctrl_wr     = bus.we && (bus.addr == ADDR_CTRL);
    assign w_preset_wr   = bus.we && (bus.addr == ADDR_PRESET);
    assign w_en          = ctrl_q[CTRL_EN];
    // MODE 1x behaves exactly like one-shot, so only 01 selects reload.
    assign w_reload_mode = (ctrl_q[2:1] == MODE_RELOAD);
    assign w_count_zero  = (count_q == '0);

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= PRESET_RST[CNT_W-1:0];
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. The FSM updates are computed first; bus writes are
    // applied afterwards so that a software CTRL write always wins over a
    // same-cycle EN clear or flag set from the FSM.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            S_IDLE: begin
                if (w_en) begin
                    state_d = S_LOAD;
                    flag_d  = 1'b0;
                end
            end

            // EN is deliberately not sampled here; a disable seen in CNT
            // returns to IDLE one cycle later.
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end

            S_CNT: begin
                if (!w_en) begin
                    state_d = S_IDLE;
                end else if (w_count_zero) begin
                    state_d = S_INT;
                    flag_d  = 1'b1;
                end else begin
                    // Only reached with COUNT != 0, so the counter never wraps.
                    count_d = count_q - CNT_W'(1);
                end
            end

            S_INT: begin
                state_d = S_IDLE;
                if (w_reload_mode) begin
                    // EN stays set, so IDLE immediately re-enters LOAD.
                    flag_d = 1'b0;
                end else begin
                    // One-shot: stop and keep the flag until software acks.
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_ctrl_wr) begin
            ctrl_d = bus.wdata[3:0];
            flag_d = 1'b0;
        end

        if (w_preset_wr) begin
            preset_d = bus.wdata[CNT_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Read mux (no read side effects) and interrupt output
    // ------------------------------------------------------------------------
    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            ADDR_CTRL:   bus.rdata = {28'd0, ctrl_q};
            ADDR_PRESET: bus.rdata = 32'(preset_q);
            ADDR_COUNT:  bus.rdata = 32'(count_q);
            default:     bus.rdata = 32'd0;
        endcase
    end

    // Masking with IM hides the request without losing the pending flag.
    assign bus.irq = ctrl_q[CTRL_IM] & flag_q;

endmodule
`default_nettype wire
